// File: rtl/dff_pkg.sv
// Shared types and constants for the flip-flop q-stream deserializer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package dff_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        STOP,
        BREAK
    } deser_state_e;

    localparam int   DESER_WIDTH_DEFAULT = 8;
    localparam logic START_BIT           = 1'b0;
    localparam logic STOP_BIT            = 1'b1;

endpackage

// File: rtl/dff_q_deserializer.sv
// Frames the sampled q stream as start/WIDTH data (LSB first)/stop words into a one-entry output register.
// Latency: start bit at edge N -> out_valid after edge N+WIDTH+1.
// Backpressure: held word is stable while !out_ready; a new good word arriving while full is dropped (sticky overrun).
//
// Ports:
//   clk, rst      - clock, asynchronous active-high reset
//   q_in          - serial bit stream, sampled every posedge
//   clr_ovr       - synchronous clear of the sticky overrun flag (set wins)
//   out_valid/out_ready/data_out - valid/ready word output, bit 0 = first data bit
//   frame_err     - one-cycle pulse when a stop bit is sampled low
//   overrun       - sticky dropped-word flag
//   busy          - FSM not in IDLE (registered with the state)
module dff_q_deserializer
    import dff_pkg::*;
#(
    parameter int WIDTH = DESER_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             q_in,
    input  logic             clr_ovr,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] data_out,
    output logic             frame_err,
    output logic             overrun,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH);

    deser_state_e     state;
    deser_state_e     state_d;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] shreg;

    logic start_det;
    logic shift_en;
    logic load_word;
    logic drop_word;
    logic bad_stop;

    // Next-state and per-cycle action decode.
    always_comb begin
        state_d   = state;
        start_det = 1'b0;
        shift_en  = 1'b0;
        load_word = 1'b0;
        drop_word = 1'b0;
        bad_stop  = 1'b0;
        case (state)
            IDLE: begin
                if (q_in == START_BIT) begin
                    start_det = 1'b1;
                    state_d   = DATA;
                end
            end
            DATA: begin
                shift_en = 1'b1;
                if (cnt == CNT_W'(WIDTH - 1)) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (q_in == STOP_BIT) begin
                    // The holding register is free if empty or being drained on this same edge.
                    if (!out_valid || out_ready) begin
                        load_word = 1'b1;
                    end else begin
                        drop_word = 1'b1;
                    end
                    state_d = IDLE;
                end else begin
                    bad_stop = 1'b1;
                    state_d  = BREAK;
                end
            end
            BREAK: begin
                // Only a return to the idle (high) level re-arms start detection.
                if (q_in == STOP_BIT) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            cnt       <= '0;
            shreg     <= '0;
            out_valid <= 1'b0;
            data_out  <= '0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state     <= state_d;
            busy      <= (state_d != IDLE);
            frame_err <= bad_stop;

            if (start_det) begin
                cnt <= '0;
            end else if (shift_en) begin
                shreg[cnt] <= q_in;
                cnt        <= cnt + 1'b1;
            end

            if (load_word) begin
                data_out  <= shreg;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            if (drop_word) begin
                overrun <= 1'b1;
            end else if (clr_ovr) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dff_q_deserializer.sv
// Self-checking bench: directed frames plus randomized traffic against a word-level reference model.
// Latency: n/a.
// Backpressure: out_ready driven per cycle by the stimulus.
module tb_dff_q_deserializer;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         q_in;
    logic         clr_ovr;
    logic         out_ready;
    logic         out_valid;
    logic [W-1:0] data_out;
    logic         frame_err;
    logic         overrun;
    logic         busy;

    dff_q_deserializer #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .q_in      (q_in),
        .clr_ovr   (clr_ovr),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .data_out  (data_out),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: state of the output word register as seen by a consumer.
    logic         m_valid;
    logic [W-1:0] m_data;
    logic         m_ferr;
    logic         m_ovr;
    logic         m_busy;

    int    n_checks;
    int    n_pass;
    string phase;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s/%s: got %0h expected %0h at %0t", phase, tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        check("out_valid", {31'b0, out_valid}, {31'b0, m_valid});
        check("data_out",  {24'b0, data_out},  {24'b0, m_data});
        check("frame_err", {31'b0, frame_err}, {31'b0, m_ferr});
        check("overrun",   {31'b0, overrun},   {31'b0, m_ovr});
        check("busy",      {31'b0, busy},      {31'b0, m_busy});
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_data  = '0;
        m_ferr  = 1'b0;
        m_ovr   = 1'b0;
        m_busy  = 1'b0;
    endtask

    // One clock: drive inputs, advance model by the frame-level event on this edge, check at negedge.
    // ev: 0 = nothing completes, 1 = good stop bit ends word, 2 = stop bit sampled low.
    task automatic tick(input logic qv, input logic rdy, input logic clr, input int ev,
                        input logic [W-1:0] word, input logic bsy);
        q_in      = qv;
        out_ready = rdy;
        clr_ovr   = clr;
        @(posedge clk);
        m_ferr = (ev == 2);
        if (clr) m_ovr = 1'b0;
        if (ev == 1) begin
            if (!m_valid || rdy) begin
                m_data  = word;
                m_valid = 1'b1;
            end else begin
                m_ovr = 1'b1;
            end
        end else if (m_valid && rdy) begin
            m_valid = 1'b0;
        end
        m_busy = bsy;
        @(negedge clk);
        check_all();
    endtask

    // rmode: 0 = ready low, 1 = ready high, 2 = random ready and occasional clr.
    function automatic logic pick_rdy(input int rmode);
        if (rmode == 2) return logic'($urandom_range(0, 1));
        return (rmode == 1);
    endfunction

    function automatic logic pick_clr(input int rmode);
        return (rmode == 2) && ($urandom_range(0, 7) == 0);
    endfunction

    // stop_rdy: -1 follows rmode, otherwise forces out_ready on the stop-bit edge.
    task automatic send_frame(input logic [W-1:0] word, input logic stop_ok,
                              input int rmode, input int stop_rdy);
        logic r;
        tick(1'b0, pick_rdy(rmode), pick_clr(rmode), 0, '0, 1'b1);
        for (int i = 0; i < W; i++) begin
            tick(word[i], pick_rdy(rmode), pick_clr(rmode), 0, '0, 1'b1);
        end
        r = (stop_rdy < 0) ? pick_rdy(rmode) : (stop_rdy != 0);
        tick(stop_ok, r, pick_clr(rmode), stop_ok ? 1 : 2, word, !stop_ok);
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) tick(1'b1, rdy, 1'b0, 0, '0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        phase     = "reset";
        rst       = 1'b1;
        q_in      = 1'b1;
        clr_ovr   = 1'b0;
        out_ready = 1'b0;
        model_reset();
        #1;
        check_all();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        idle(2, 1'b1);

        phase = "single_a5";
        send_frame(8'hA5, 1'b1, 1, -1);
        idle(2, 1'b1);

        phase = "back_to_back";
        send_frame(8'h3C, 1'b1, 1, -1);
        send_frame(8'hFF, 1'b1, 1, -1);
        idle(2, 1'b1);

        phase = "backpressure";
        send_frame(8'h11, 1'b1, 0, -1);
        send_frame(8'h22, 1'b1, 0, -1);
        tick(1'b1, 1'b0, 1'b1, 0, '0, 1'b0);
        idle(1, 1'b0);

        phase = "xfer_and_load";
        send_frame(8'h22, 1'b1, 0, 1);
        idle(2, 1'b1);

        phase = "frame_err";
        send_frame(8'h55, 1'b0, 1, -1);
        for (int i = 0; i < 5; i++) tick(1'b0, 1'b1, 1'b0, 0, '0, 1'b1);
        tick(1'b1, 1'b1, 1'b0, 0, '0, 1'b0);
        send_frame(8'h0F, 1'b1, 1, -1);
        idle(2, 1'b1);

        phase = "reset_mid_frame";
        send_frame(8'h99, 1'b1, 0, -1);
        send_frame(8'h77, 1'b1, 0, -1);
        tick(1'b0, 1'b0, 1'b0, 0, '0, 1'b1);
        for (int i = 0; i < 4; i++) tick(i[0], 1'b0, 1'b0, 0, '0, 1'b1);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check_all();
        @(negedge clk);
        rst  = 1'b0;
        q_in = 1'b1;
        idle(1, 1'b1);
        send_frame(8'hC3, 1'b1, 1, -1);
        idle(2, 1'b1);

        phase = "random";
        for (int f = 0; f < 40; f++) begin
            logic [W-1:0] w;
            logic         ok;
            w  = W'($urandom);
            ok = ($urandom_range(0, 5) != 0);
            send_frame(w, ok, 2, -1);
            if (!ok) begin
                for (int i = 0; i < int'($urandom_range(0, 3)); i++)
                    tick(1'b0, pick_rdy(2), 1'b0, 0, '0, 1'b1);
                tick(1'b1, pick_rdy(2), 1'b0, 0, '0, 1'b0);
            end
            for (int i = 0; i < int'($urandom_range(0, 2)); i++)
                tick(1'b1, pick_rdy(2), pick_clr(2), 0, '0, 1'b0);
        end
        idle(2, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
